// File: rtl/preprocess_fmac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : preprocess_fmac_pipe
// Description : Registered FMAC operand preprocessor. Splits packed IEEE-754
//               operands, classifies them and optionally normalises denormals.
// Revision    : 1.0 - initial release
// ============================================================================
module preprocess_fmac_pipe #(
    parameter int C_EXP         = 8,
    parameter int C_MANT        = 23,
    parameter int C_NUM_OPS     = 3,
    parameter int C_TAG         = 4,
    parameter int C_NORM_DENORM = 1
) (
    input  logic                                  Clk_CI,
    input  logic                                  Rst_RI,
    input  logic                                  In_valid_SI,
    output logic                                  In_ready_SO,
    input  logic [C_NUM_OPS*(1+C_EXP+C_MANT)-1:0] Operands_DI,
    input  logic [C_TAG-1:0]                      Tag_DI,
    output logic                                  Out_valid_SO,
    input  logic                                  Out_ready_SI,
    output logic [C_NUM_OPS-1:0]                  Sign_DO,
    output logic [C_NUM_OPS*(C_EXP+2)-1:0]        Exp_DO,
    output logic [C_NUM_OPS*(C_MANT+1)-1:0]       Mant_DO,
    output logic [C_NUM_OPS-1:0]                  Zero_SO,
    output logic [C_NUM_OPS-1:0]                  Inf_SO,
    output logic [C_NUM_OPS-1:0]                  NaN_SO,
    output logic [C_NUM_OPS-1:0]                  SNaN_SO,
    output logic [C_NUM_OPS-1:0]                  DeN_SO,
    output logic [C_TAG-1:0]                      Tag_DO
);
    localparam int C_W  = 1 + C_EXP + C_MANT;
    localparam int C_EW = C_EXP + 2;
    localparam int C_MW = C_MANT + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt, w_state_load;

    logic [C_NUM_OPS-1:0]      w_dec_sign, w_dec_zero, w_dec_inf, w_dec_nan, w_dec_snan, w_dec_den;
    logic [C_NUM_OPS*C_EW-1:0] w_dec_exp, w_norm_exp;
    logic [C_NUM_OPS*C_MW-1:0] w_dec_mant, w_norm_mant;
    logic [C_NUM_OPS-1:0]      w_more;

    logic [C_NUM_OPS-1:0]      r_sign, r_zero, r_inf, r_nan, r_snan, r_den;
    logic [C_NUM_OPS*C_EW-1:0] r_exp;
    logic [C_NUM_OPS*C_MW-1:0] r_mant;
    logic [C_TAG-1:0]          r_tag;

    logic w_in_ready, w_out_valid, w_accept;

    for (genvar i = 0; i < C_NUM_OPS; i++) begin : g_op
        logic [C_EXP-1:0]  w_ef;
        logic [C_MANT-1:0] w_mf;
        logic              w_ef_zero, w_ef_ones, w_mf_nz, w_shift;

        assign w_ef      = Operands_DI[i*C_W+C_MANT +: C_EXP];
        assign w_mf      = Operands_DI[i*C_W +: C_MANT];
        assign w_ef_zero = ~|w_ef;
        assign w_ef_ones = &w_ef;
        assign w_mf_nz   = |w_mf;

        assign w_dec_sign[i]               = Operands_DI[i*C_W + C_W - 1];
        assign w_dec_exp[i*C_EW +: C_EW]   = w_ef_zero ? C_EW'(1) : {2'b00, w_ef};
        assign w_dec_mant[i*C_MW +: C_MW]  = {~w_ef_zero, w_mf};
        assign w_dec_zero[i]               = w_ef_zero & ~w_mf_nz;
        assign w_dec_den[i]                = w_ef_zero &  w_mf_nz;
        assign w_dec_inf[i]                = w_ef_ones & ~w_mf_nz;
        assign w_dec_nan[i]                = w_ef_ones &  w_mf_nz;
        assign w_dec_snan[i]               = w_ef_ones &  w_mf_nz & ~w_mf[C_MANT-1];

        // One normalisation step; w_more flags operands still lacking a leading 1 afterwards.
        assign w_shift = r_den[i] & ~r_mant[i*C_MW + C_MANT];
        assign w_norm_mant[i*C_MW +: C_MW] = w_shift ? {r_mant[i*C_MW +: C_MANT], 1'b0}
                                                     : r_mant[i*C_MW +: C_MW];
        assign w_norm_exp[i*C_EW +: C_EW]  = w_shift ? r_exp[i*C_EW +: C_EW] - C_EW'(1)
                                                     : r_exp[i*C_EW +: C_EW];
        assign w_more[i] = r_den[i] & ~w_norm_mant[i*C_MW + C_MANT];
    end

    assign w_state_load = ((C_NORM_DENORM != 0) && (|w_dec_den)) ? S_NORM : S_DONE;
    assign w_accept     = In_valid_SI & w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (In_valid_SI) w_state_nxt = w_state_load;
            end
            S_NORM: begin
                if (~|w_more) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = Out_ready_SI;
                if (Out_ready_SI) w_state_nxt = In_valid_SI ? w_state_load : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state <= S_IDLE;
            r_sign  <= '0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_zero  <= '0;
            r_inf   <= '0;
            r_nan   <= '0;
            r_snan  <= '0;
            r_den   <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sign <= w_dec_sign;
                r_exp  <= w_dec_exp;
                r_mant <= w_dec_mant;
                r_zero <= w_dec_zero;
                r_inf  <= w_dec_inf;
                r_nan  <= w_dec_nan;
                r_snan <= w_dec_snan;
                r_den  <= w_dec_den;
                r_tag  <= Tag_DI;
            end else if (r_state == S_NORM) begin
                r_exp  <= w_norm_exp;
                r_mant <= w_norm_mant;
            end
        end
    end

    assign In_ready_SO  = w_in_ready;
    assign Out_valid_SO = w_out_valid;
    assign Sign_DO      = r_sign;
    assign Exp_DO       = r_exp;
    assign Mant_DO      = r_mant;
    assign Zero_SO      = r_zero;
    assign Inf_SO       = r_inf;
    assign NaN_SO       = r_nan;
    assign SNaN_SO      = r_snan;
    assign DeN_SO       = r_den;
    assign Tag_DO       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_preprocess_fmac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_preprocess_fmac_pipe
// Description : Scoreboard bench for preprocess_fmac_pipe (single precision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preprocess_fmac_pipe;
    typedef struct packed {
        logic       s;
        logic [9:0] e;
        logic [23:0] m;
        logic       z, inf, nan, snan, den;
    } dec_t;
    typedef struct packed {
        dec_t [2:0] d;
        logic [3:0] tag;
    } txn_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [95:0] ops = '0;
    logic [3:0]  tag = '0, tag_o;
    logic [2:0]  sign, zero, inf, nan, snan, den;
    logic [29:0] expo;
    logic [71:0] mant;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [95:0] b_ops = '0;
    logic [3:0]  b_tag = '0, b_tag_o;
    logic [2:0]  b_sign, b_zero, b_inf, b_nan, b_snan, b_den;
    logic [29:0] b_expo;
    logic [71:0] b_mant;

    preprocess_fmac_pipe u_dut (
        .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(in_valid), .In_ready_SO(in_ready),
        .Operands_DI(ops), .Tag_DI(tag), .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
        .Sign_DO(sign), .Exp_DO(expo), .Mant_DO(mant), .Zero_SO(zero), .Inf_SO(inf),
        .NaN_SO(nan), .SNaN_SO(snan), .DeN_SO(den), .Tag_DO(tag_o)
    );

    preprocess_fmac_pipe #(.C_NORM_DENORM(0)) u_byp (
        .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(b_in_valid), .In_ready_SO(b_in_ready),
        .Operands_DI(b_ops), .Tag_DI(b_tag), .Out_valid_SO(b_out_valid), .Out_ready_SI(b_out_ready),
        .Sign_DO(b_sign), .Exp_DO(b_expo), .Mant_DO(b_mant), .Zero_SO(b_zero), .Inf_SO(b_inf),
        .NaN_SO(b_nan), .SNaN_SO(b_snan), .DeN_SO(b_den), .Tag_DO(b_tag_o)
    );

    int   n_vec = 0, n_err = 0;
    txn_t sb[$];
    bit   or_rand = 1'b0, or_val = 1'b1;

    // Reference decode from the IEEE-754 field rules, normalising by repeated doubling.
    function automatic dec_t model(input logic [31:0] op, input bit norm);
        dec_t d;
        int ef = int'(op[30:23]);
        int mf = int'(op[22:0]);
        int e, m;
        d.s    = op[31];
        d.z    = (ef == 0)   && (mf == 0);
        d.den  = (ef == 0)   && (mf != 0);
        d.inf  = (ef == 255) && (mf == 0);
        d.nan  = (ef == 255) && (mf != 0);
        d.snan = d.nan && (mf < 32'h400000);
        if (ef == 0) begin
            e = 1;
            m = mf;
            if (norm && mf != 0)
                while (m < 32'h800000) begin
                    m = m * 2;
                    e = e - 1;
                end
        end else begin
            e = ef;
            m = mf + 32'h800000;
        end
        d.e = e[9:0];
        d.m = m[23:0];
        return d;
    endfunction

    function automatic txn_t model_txn(input logic [95:0] o, input logic [3:0] t, input bit norm);
        txn_t r;
        for (int i = 0; i < 3; i++) r.d[i] = model(o[i*32 +: 32], norm);
        r.tag = t;
        return r;
    endfunction

    function automatic txn_t pack(input logic [2:0] s, input logic [29:0] e, input logic [71:0] m,
                                  input logic [2:0] z, input logic [2:0] f, input logic [2:0] n,
                                  input logic [2:0] sn, input logic [2:0] dn, input logic [3:0] t);
        txn_t r;
        for (int i = 0; i < 3; i++) begin
            r.d[i].s    = s[i];
            r.d[i].e    = e[i*10 +: 10];
            r.d[i].m    = m[i*24 +: 24];
            r.d[i].z    = z[i];
            r.d[i].inf  = f[i];
            r.d[i].nan  = n[i];
            r.d[i].snan = sn[i];
            r.d[i].den  = dn[i];
        end
        r.tag = t;
        return r;
    endfunction

    function automatic txn_t actual();
        return pack(sign, expo, mant, zero, inf, nan, snan, den, tag_o);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: owns Out_ready and retires results against the scoreboard.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_val;
            #1;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got tag %h, expected no result", tag_o);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", 128'(actual()), 128'(e));
                end
            end
        end
    end

    task automatic send(input logic [95:0] o, input logic [3:0] t, input bit wait_lat, output int lat);
        bit acc = 1'b0;
        int guard = 0;
        lat = 0;
        while (!acc) begin
            @(negedge clk);
            in_valid = 1'b1;
            ops      = o;
            tag      = t;
            #1;
            acc = in_ready;
            guard++;
            if (!acc && guard > 200) begin
                chk("accept_timeout", 128'(in_ready), 128'(1));
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back(model_txn(o, t, 1'b1));
        @(posedge clk);
        if (wait_lat) begin
            lat = 1;
            forever begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid || lat > 100) break;
                lat++;
            end
        end
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r = $urandom;
        logic        s = r[31];
        case ($urandom_range(0, 4))
            0:       return {s, 31'h0};
            1:       return {s, 8'h00, 23'($urandom >> $urandom_range(9, 31))};
            2:       return {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom)};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    localparam logic [31:0] ONE = 32'h3F800000;

    initial begin
        int   lat;
        txn_t e5;
        #50000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        txn_t        e5, eb;
        logic [95:0] o;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", {out_valid, in_ready, actual()}, {1'b0, 1'b1, 124'b0});

        send({32'h0, 32'hC0000000, ONE}, 4'd1, 1'b1, lat);
        chk("lat_normal", 128'(lat), 128'(1));
        chk("exp_normal", 128'(expo), 128'({10'd1, 10'd128, 10'd127}));
        chk("mant_normal", 128'(mant), 128'({24'h000000, 24'h800000, 24'h800000}));

        send({ONE, ONE, 32'h00000001}, 4'd2, 1'b1, lat);
        chk("lat_den23", 128'(lat), 128'(24));
        chk("exp_den23", 128'({expo[9:0], mant[23:0], den}), 128'({10'h3EA, 24'h800000, 3'b001}));

        send({ONE, ONE, 32'h00400000}, 4'd3, 1'b1, lat);
        chk("lat_den1", 128'(lat), 128'(2));
        chk("exp_den1", 128'({expo[9:0], mant[23:0]}), 128'({10'd0, 24'h800000}));

        send({32'h7F800000, 32'h7FC00000, 32'h7FA00000}, 4'd4, 1'b1, lat);
        chk("nan_flags", 128'({nan, snan, inf, expo}),
            128'({3'b011, 3'b001, 3'b100, 10'd255, 10'd255, 10'd255}));

        // Backpressure: hold DONE, then release with a new input on the same edge.
        or_val = 1'b0;
        send({ONE, ONE, ONE}, 4'd5, 1'b1, lat);
        chk("lat_bp", 128'(lat), 128'(1));
        e5 = model_txn({ONE, ONE, ONE}, 4'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ops      = {ONE, 32'h40400000, ONE};
            tag      = 4'd6;
            #1;
            chk("bp_hold", {out_valid, in_ready, actual()}, {1'b1, 1'b0, e5});
        end
        or_val = 1'b1;
        send({ONE, 32'h40400000, ONE}, 4'd6, 1'b0, lat);
        drop();
        #1;
        chk("b2b", 128'({out_valid, tag_o}), 128'({1'b1, 4'd6}));

        // Reset during normalisation drops the transaction.
        send({ONE, ONE, 32'h00000001}, 4'd7, 1'b0, lat);
        drop();
        repeat (8) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("reset_mid_norm", {out_valid, in_ready, actual()}, {1'b0, 1'b1, 124'b0});
        send({ONE, ONE, ONE}, 4'd8, 1'b1, lat);
        chk("lat_after_rst", 128'(lat), 128'(1));

        // Bypass instance: denormal passes through untouched with latency 1.
        @(negedge clk);
        b_in_valid = 1'b1;
        b_ops      = {ONE, ONE, 32'h00400000};
        b_tag      = 4'd9;
        #1;
        chk("byp_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        eb = model_txn({ONE, ONE, 32'h00400000}, 4'd9, 1'b0);
        chk("byp_lat1", 128'({b_out_valid, b_expo[9:0], b_mant[23:0]}), 128'({1'b1, 10'd1, 24'h400000}));
        chk("byp_result",
            128'(pack(b_sign, b_expo, b_mant, b_zero, b_inf, b_nan, b_snan, b_den, b_tag_o)),
            128'(eb));

        or_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            o = {rand_op(), rand_op(), rand_op()};
            send(o, 4'($urandom), 1'b0, lat);
            if ($urandom_range(0, 3) == 0) drop();
        end
        drop();
        for (int c = 0; c < 1000 && sb.size() != 0; c++) @(negedge clk);
        chk("sb_drain", 128'(sb.size()), 128'(0));
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
